// File: rtl/frame_scheduler_if.sv
// Frame-tick, object mask/done and plot-port grant bundle for frame_scheduler.
// The master side drives ticks and requester handshakes; the slave side is the scheduler.
interface frame_scheduler_if #(
    parameter int N_OBJ = 4
);
    logic             frame_tick;
    logic             enable;
    logic [N_OBJ-1:0] obj_mask;
    logic [N_OBJ-1:0] obj_done;
    logic [N_OBJ-1:0] grant;
    logic             erase;
    logic             update;
    logic             busy;
    logic             frame_overrun;
    logic [7:0]       frame_count;
    logic             timeout_err;

    modport master (
        output frame_tick, enable, obj_mask, obj_done,
        input  grant, erase, update, busy, frame_overrun, frame_count, timeout_err
    );

    modport slave (
        input  frame_tick, enable, obj_mask, obj_done,
        output grant, erase, update, busy, frame_overrun, frame_count, timeout_err
    );
endinterface

// File: rtl/frame_scheduler.sv
// Per-frame erase -> update -> draw sequencer granting the shared plot port one object at a time.
// Optional FRAME_SCHED_TIMEOUT_EN force-completes a grant after TIMEOUT_CYCLES and flags timeout_err.
module frame_scheduler #(
    parameter int N_OBJ          = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    frame_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_UPDATE, S_DRAW} state_t;

    if ((2 ** IDX_W) < N_OBJ) begin : g_bad_idx_w
        $error("IDX_W too narrow for N_OBJ");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_OBJ-1:0] mask_q, mask_d;
    logic [N_OBJ-1:0] grant_q, grant_d;
    logic [7:0]       count_q, count_d;
    logic             erase_q, update_q, busy_q, overrun_q;

    logic phase, phase_d, sel_on, sel_done, gnt_act, slot_done, last, tmo_hit;

    // Current slot's mask and done bit, selected without indexing past N_OBJ
    always_comb begin
        sel_on   = 1'b0;
        sel_done = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_on   = mask_q[i];
                sel_done = bus.obj_done[i];
            end
        end
    end

    assign phase     = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign gnt_act   = phase && sel_on;
    assign slot_done = !sel_on || sel_done || tmo_hit;
    assign last      = (idx_q == IDX_W'(N_OBJ - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_tick && bus.enable) begin
                    state_d = S_ERASE;
                    idx_d   = '0;
                    mask_d  = bus.obj_mask;
                end
            end
            S_ERASE, S_DRAW: begin
                if (slot_done) begin
                    if (last) begin
                        idx_d = '0;
                        if (state_q == S_ERASE) begin
                            state_d = S_UPDATE;
                        end else begin
                            state_d = S_IDLE;
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_UPDATE: begin
                state_d = S_DRAW;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next state so they register alongside it
    assign phase_d = (state_d == S_ERASE) || (state_d == S_DRAW);

    for (genvar i = 0; i < N_OBJ; i++) begin : g_lane
        assign grant_d[i] = phase_d && mask_d[i] && (idx_d == IDX_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            grant_q   <= '0;
            erase_q   <= 1'b0;
            update_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
            erase_q  <= (state_d == S_ERASE);
            update_q <= (state_d == S_UPDATE);
            busy_q   <= (state_d != S_IDLE);
            // Ticks while busy are dropped, including one on the final draw done
            if (bus.frame_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef FRAME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_err_q;

    assign tmo_hit = gnt_act && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Restart on every slot change so each grant rise begins at zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (!gnt_act || slot_done) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (tmo_hit && !sel_done) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant         = grant_q;
    assign bus.erase         = erase_q;
    assign bus.update        = update_q;
    assign bus.busy          = busy_q;
    assign bus.frame_overrun = overrun_q;
    assign bus.frame_count   = count_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: per-cycle grant/erase/update/busy tables plus sticky flags.
module tb_frame_scheduler;
    localparam int N = 4;

    typedef struct {
        logic [3:0] g;
        logic       e;
        logic       u;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    frame_scheduler_if #(.N_OBJ(N)) bus ();

    frame_scheduler #(
        .N_OBJ(N),
        .IDX_W(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   done_mode = 0;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester model: 0 never done, 1 done always high, 2 done on 3rd grant cycle,
    // 3 done immediately except object 1 which never answers
    logic [3:0] gprev = 4'h0;
    int         gcnt = 0;
    always @(negedge clk) begin
        if (bus.grant != 4'h0 && bus.grant == gprev) gcnt++;
        else gcnt = (bus.grant != 4'h0) ? 1 : 0;
        gprev = bus.grant;
        case (done_mode)
            1:       bus.obj_done = 4'hF;
            2:       bus.obj_done = (gcnt >= 3) ? bus.grant : 4'h0;
            3:       bus.obj_done = bus.grant & 4'b1101;
            default: bus.obj_done = 4'h0;
        endcase
    end

    task automatic push(input logic [3:0] g, input logic e, input logic u, input logic b, input int n);
        exp_t x;
        x.g = g; x.e = e; x.u = u; x.b = b;
        repeat (n) q.push_back(x);
    endtask

    task automatic start_frame(input logic [3:0] mask);
        @(negedge clk);
        bus.obj_mask   = mask;
        bus.enable     = 1'b1;
        bus.frame_tick = 1'b1;
    endtask

    // Cycle k samples outputs at negedge k; a tick at k is seen by the edge ending cycle k
    task automatic run_seq(input string name, input int tick_a, input int tick_b);
        for (int k = 1; k <= q.size(); k++) begin
            @(negedge clk);
            bus.frame_tick = (k == tick_a) || (k == tick_b);
            chk($sformatf("%s[%0d].grant", name, k), 32'(bus.grant), 32'(q[k-1].g));
            chk($sformatf("%s[%0d].erase", name, k), 32'(bus.erase), 32'(q[k-1].e));
            chk($sformatf("%s[%0d].update", name, k), 32'(bus.update), 32'(q[k-1].u));
            chk($sformatf("%s[%0d].busy", name, k), 32'(bus.busy), 32'(q[k-1].b));
        end
        bus.frame_tick = 1'b0;
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn         = 1'b0;
        bus.frame_tick = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic push_full(input logic [3:0] per);
        for (int p = 0; p < 2; p++) begin
            push(4'b0001, p == 0, 1'b0, 1'b1, int'(per));
            push(4'b0010, p == 0, 1'b0, 1'b1, int'(per));
            push(4'b0100, p == 0, 1'b0, 1'b1, int'(per));
            push(4'b1000, p == 0, 1'b0, 1'b1, int'(per));
            if (p == 0) push(4'b0000, 1'b0, 1'b1, 1'b1, 1);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b0;
        bus.obj_mask   = 4'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.grant", 32'(bus.grant), 32'h0);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        chk("rst.update", 32'(bus.update), 32'h0);
        chk("rst.erase", 32'(bus.erase), 32'h0);
        chk("rst.overrun", 32'(bus.frame_overrun), 32'h0);
        chk("rst.count", 32'(bus.frame_count), 32'h0);
        chk("rst.timeout", 32'(bus.timeout_err), 32'h0);
        resetn = 1'b1;

        // Tick with enable low is ignored and is not an overrun
        @(negedge clk);
        bus.enable = 1'b0; bus.obj_mask = 4'hF; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("dis.busy", 32'(bus.busy), 32'h0);
        chk("dis.overrun", 32'(bus.frame_overrun), 32'h0);

        // 1: all active, done on 3rd grant cycle
        done_mode = 2;
        push_full(4'd3);
        push(4'b0000, 1'b0, 1'b0, 1'b0, 2);
        start_frame(4'hF);
        run_seq("t1", 0, 0);
        chk("t1.count", 32'(bus.frame_count), 32'd1);
        chk("t1.overrun", 32'(bus.frame_overrun), 32'h0);

        // 2: all masked, 9 busy cycles, update on the 5th
        do_reset();
        done_mode = 0;
        push(4'b0000, 1'b1, 1'b0, 1'b1, 4);
        push(4'b0000, 1'b0, 1'b1, 1'b1, 1);
        push(4'b0000, 1'b0, 1'b0, 1'b1, 4);
        push(4'b0000, 1'b0, 1'b0, 1'b0, 2);
        start_frame(4'h0);
        run_seq("t2", 0, 0);
        chk("t2.count", 32'(bus.frame_count), 32'd1);

        // 3: mask 0101, done always high
        do_reset();
        done_mode = 1;
        for (int p = 0; p < 2; p++) begin
            push(4'b0001, p == 0, 1'b0, 1'b1, 1);
            push(4'b0000, p == 0, 1'b0, 1'b1, 1);
            push(4'b0100, p == 0, 1'b0, 1'b1, 1);
            push(4'b0000, p == 0, 1'b0, 1'b1, 1);
            if (p == 0) push(4'b0000, 1'b0, 1'b1, 1'b1, 1);
        end
        push(4'b0000, 1'b0, 1'b0, 1'b0, 2);
        start_frame(4'b0101);
        run_seq("t3", 0, 0);
        chk("t3.count", 32'(bus.frame_count), 32'd1);
        chk("t3.overrun", 32'(bus.frame_overrun), 32'h0);

        // 4a: tick on the same cycle as the final draw done
        do_reset();
        push_full(4'd1);
        push(4'b0000, 1'b0, 1'b0, 1'b0, 2);
        start_frame(4'hF);
        run_seq("t4a", 9, 0);
        chk("t4a.overrun", 32'(bus.frame_overrun), 32'h1);
        chk("t4a.count", 32'(bus.frame_count), 32'd1);

        // 4b: tick mid draw pass
        do_reset();
        push_full(4'd1);
        push(4'b0000, 1'b0, 1'b0, 1'b0, 2);
        start_frame(4'hF);
        run_seq("t4b", 7, 0);
        chk("t4b.overrun", 32'(bus.frame_overrun), 32'h1);
        chk("t4b.count", 32'(bus.frame_count), 32'd1);

        // 5: reset while grant=0010 in draw pass
        do_reset();
        done_mode = 2;
        push_full(4'd3);
        while (q.size() > 17) void'(q.pop_back());
        start_frame(4'hF);
        run_seq("t5", 0, 0);
        resetn = 1'b0;
        @(negedge clk);
        chk("t5.grant", 32'(bus.grant), 32'h0);
        chk("t5.busy", 32'(bus.busy), 32'h0);
        chk("t5.count", 32'(bus.frame_count), 32'd0);
        chk("t5.overrun", 32'(bus.frame_overrun), 32'h0);
        resetn = 1'b1;

        // frame_count wraps 255 -> 0
        do_reset();
        done_mode = 0;
        for (int f = 1; f <= 256; f++) begin
            start_frame(4'h0);
            @(negedge clk);
            bus.frame_tick = 1'b0;
            repeat (9) @(negedge clk);
            if (f == 255) chk("wrap.255", 32'(bus.frame_count), 32'd255);
        end
        chk("wrap.0", 32'(bus.frame_count), 32'd0);
        chk("wrap.busy", 32'(bus.busy), 32'h0);

`ifdef FRAME_SCHED_TIMEOUT_EN
        // 6: object 1 never answers, forced out after 16 cycles in each pass
        do_reset();
        done_mode = 3;
        for (int p = 0; p < 2; p++) begin
            push(4'b0001, p == 0, 1'b0, 1'b1, 1);
            push(4'b0010, p == 0, 1'b0, 1'b1, 16);
            push(4'b0100, p == 0, 1'b0, 1'b1, 1);
            push(4'b1000, p == 0, 1'b0, 1'b1, 1);
            if (p == 0) push(4'b0000, 1'b0, 1'b1, 1'b1, 1);
        end
        push(4'b0000, 1'b0, 1'b0, 1'b0, 1);
        start_frame(4'hF);
        run_seq("t6", 0, 0);
        chk("t6.timeout", 32'(bus.timeout_err), 32'h1);
        chk("t6.count", 32'(bus.frame_count), 32'd1);
`else
        chk("notmo.timeout", 32'(bus.timeout_err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
